vram_row_fetch: RTL

- Responder side of the display row-buffer interface.
- On a row request (vram_re, vram_y), reads one horizontally scaled VRAM row through a pipelined read port.
- Converts each 15bpp PSX pixel to 24bpp.
- Streams SCREEN_W write beats (vram_we, vram_x, vram_out) into the display row buffer, all on clk_50MHz.

---
 rtl/vram_row_fetch_if.sv | 34 +++
 rtl/vram_row_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vram_row_fetch_if.sv
// vram_row_fetch_if: display row-request, VRAM read-port and row-buffer write signals.
//   master : fetch engine (accepts row requests, issues VRAM reads, writes the row buffer)
//   slave  : surrounding display / VRAM logic
//   Signals: vram_re/vram_y/x_tl/dis_w (row request), mem_re/mem_addr/mem_gnt (read issue),
//            mem_rvalid/mem_rdata (in-order read return), vram_we/vram_x/vram_out (row buffer
//            write), busy/overrun (status).
interface vram_row_fetch_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              vram_re;
    logic [8:0]        vram_y;
    logic [9:0]        x_tl;
    logic [9:0]        dis_w;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [15:0]       mem_rdata;
    logic              vram_we;
    logic [9:0]        vram_x;
    logic [23:0]       vram_out;
    logic              busy;
    logic              overrun;

    modport master (
        input  vram_re, vram_y, x_tl, dis_w, mem_gnt, mem_rvalid, mem_rdata,
        output mem_re, mem_addr, vram_we, vram_x, vram_out, busy, overrun
    );

    modport slave (
        output vram_re, vram_y, x_tl, dis_w, mem_gnt, mem_rvalid, mem_rdata,
        input  mem_re, mem_addr, vram_we, vram_x, vram_out, busy, overrun
    );
endinterface

// File: rtl/vram_row_fetch.sv
// vram_row_fetch: on a row request, reads one horizontally scaled VRAM row through a
// pipelined read port, expands 15bpp pixels to 24bpp and streams SCREEN_W beats into the
// display row buffer.
//   clk_50MHz : clock
//   rst       : asynchronous active-high reset
//   bus       : vram_row_fetch_if.master (row request, VRAM read port, row buffer write, status)
// Build option: define COLOR_REPLICATE_EN to expand 5-bit channels by bit replication
// ({c, c[4:2]}); otherwise channels are zero-padded ({c, 3'b000}).
module vram_row_fetch #(
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned ADDR_W    = 19
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    vram_row_fetch_if.master bus
);
    localparam int unsigned CNT_W  = $clog2(SCREEN_W + 1);
    localparam int unsigned OUT_W  = $clog2(MAX_OUTST + 1);
    localparam int unsigned FRAC_W = 11;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_n;
    logic [8:0]        y_q, y_n;
    logic [9:0]        w_q, w_n;
    logic [9:0]        src_x_q, src_x_n;
    logic [FRAC_W-1:0] frac_q, frac_n;
    logic [CNT_W-1:0]  issue_q, issue_n;
    logic [CNT_W-1:0]  ret_q, ret_n;
    logic [OUT_W-1:0]  outst_q, outst_n;
    logic              mem_re_q, mem_re_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              we_q, we_n;
    logic [9:0]        x_q, x_n;
    logic [23:0]       out_q, out_n;
    logic              busy_q, busy_n;
    logic              overrun_q, overrun_n;

    logic              grant;
    logic              ret;
    logic [FRAC_W-1:0] frac_sum;
    logic              unused_mask;

    assign unused_mask = bus.mem_rdata[15];

    // 5-bit colour channel to 8 bits
    function automatic logic [7:0] expand5(input logic [4:0] c);
`ifdef COLOR_REPLICATE_EN
        return {c, c[4:2]};
`else
        return {c, 3'b000};
`endif
    endfunction

    // State register and all datapath registers
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= '0;
            w_q       <= '0;
            src_x_q   <= '0;
            frac_q    <= '0;
            issue_q   <= '0;
            ret_q     <= '0;
            outst_q   <= '0;
            mem_re_q  <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            x_q       <= '0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            y_q       <= y_n;
            w_q       <= w_n;
            src_x_q   <= src_x_n;
            frac_q    <= frac_n;
            issue_q   <= issue_n;
            ret_q     <= ret_n;
            outst_q   <= outst_n;
            mem_re_q  <= mem_re_n;
            addr_q    <= addr_n;
            we_q      <= we_n;
            x_q       <= x_n;
            out_q     <= out_n;
            busy_q    <= busy_n;
            overrun_q <= overrun_n;
        end
    end

    // Next-state, DDA issue path and return path
    always_comb begin
        state_n   = state_q;
        y_n       = y_q;
        w_n       = w_q;
        src_x_n   = src_x_q;
        frac_n    = frac_q;
        issue_n   = issue_q;
        ret_n     = ret_q;
        busy_n    = busy_q;
        overrun_n = overrun_q;
        we_n      = 1'b0;
        x_n       = x_q;
        out_n     = out_q;

        grant    = mem_re_q && bus.mem_gnt;
        ret      = bus.mem_rvalid && (outst_q != '0);
        frac_sum = frac_q + FRAC_W'(w_q);

        // A request anywhere but IDLE (including the DRAIN->IDLE cycle) is dropped
        if (bus.vram_re && (state_q != IDLE)) begin
            overrun_n = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.vram_re) begin
                    y_n     = bus.vram_y;
                    w_n     = (32'(bus.dis_w) > SCREEN_W) ? 10'(SCREEN_W) : bus.dis_w;
                    src_x_n = bus.x_tl;
                    frac_n  = '0;
                    issue_n = '0;
                    ret_n   = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (issue_q == CNT_W'(SCREEN_W)) begin
                    state_n = DRAIN;
                end else if (grant) begin
                    issue_n = issue_q + CNT_W'(1);
                    // Clamped width keeps frac_sum < 2*SCREEN_W: at most one source step
                    if (frac_sum >= FRAC_W'(SCREEN_W)) begin
                        frac_n  = frac_sum - FRAC_W'(SCREEN_W);
                        src_x_n = src_x_q + 10'd1;
                    end else begin
                        frac_n  = frac_sum;
                    end
                end
            end
            DRAIN: begin
                if (ret_q == CNT_W'(SCREEN_W)) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Return data only counts against a read we actually issued
        if (ret) begin
            we_n  = 1'b1;
            x_n   = 10'(ret_q);
            out_n = {expand5(bus.mem_rdata[14:10]),
                     expand5(bus.mem_rdata[9:5]),
                     expand5(bus.mem_rdata[4:0])};
            ret_n = ret_q + CNT_W'(1);
        end

        outst_n = outst_q + OUT_W'(grant) - OUT_W'(ret);

        // Derived from next values so request/address stay put until granted
        mem_re_n = (state_n == RUN) && (issue_n < CNT_W'(SCREEN_W)) &&
                   (outst_n < OUT_W'(MAX_OUTST));
        addr_n   = ADDR_W'({y_n, src_x_n});
    end

    assign bus.mem_re   = mem_re_q;
    assign bus.mem_addr = addr_q;
    assign bus.vram_we  = we_q;
    assign bus.vram_x   = x_q;
    assign bus.vram_out = out_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;
endmodule
